// File: rtl/uart_fifo_pkg.sv
// Shared constants, state encodings and status-bit positions for the UART/FIFO
// command sequencer.
package uart_fifo_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] NAK   = 8'hEE;

  // Bit positions inside the 'S' status byte.
  localparam int ST_FULL  = 7;
  localparam int ST_EMPTY = 6;
  localparam int ST_OVF   = 5;
  localparam int ST_TOUT  = 4;

  typedef enum logic [3:0] {
    IDLE, W_LEN, W_DATA, R_HDR, R_CNT, R_FETCH, R_LAT, R_SEND, S_SEND, TX_NAK
  } state_t;

  typedef enum logic [1:0] {SQ_IDLE, SQ_WAIT, SQ_GUARD, SQ_DRAIN} tx_state_t;

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// One-byte transmit handshake: wait for an idle transmitter, strobe tx_wr,
// skip one guard cycle, then wait for the transmitter to finish.
module uart_tx_seq
  import uart_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       done
);

  tx_state_t st;

  // Combinational so the caller can change state on the same edge the
  // sequencer returns to idle, and never re-triggers a byte.
  assign done = (st == SQ_DRAIN) && !tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= SQ_IDLE;
      tx_wr   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_wr <= 1'b0;
      case (st)
        SQ_IDLE:  if (start) begin
                    tx_data <= tx_byte;
                    st      <= SQ_WAIT;
                  end
        SQ_WAIT:  if (!tx_busy) begin
                    tx_wr <= 1'b1;
                    st    <= SQ_GUARD;
                  end
        SQ_GUARD: st <= SQ_DRAIN;
        SQ_DRAIN: if (!tx_busy) st <= SQ_IDLE;
        default:  st <= SQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Command sequencer between UART and the camera byte FIFO: 'W' loads bytes,
// 'R' dumps them framed as HDR,count,data..., 'S' reports status.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] HDR     = 8'hA0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_avail,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  input  logic                     tx_busy,
  output logic                     fifo_wr,
  output logic [7:0]               fifo_din,
  output logic                     fifo_rd,
  input  logic [7:0]               fifo_dout,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     tout
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    bcnt, cnt, rdata, seq_byte;
  logic [TW-1:0] tcnt;
  logic          zfill, seq_start, seq_done, enter_fetch, in_w;

  always_comb begin
    seq_start = 1'b1;
    seq_byte  = 8'h00;
    case (state)
      R_HDR:   seq_byte = HDR;
      R_CNT:   seq_byte = cnt;
      R_SEND:  seq_byte = rdata;
      S_SEND: begin
        seq_byte[ST_FULL]  = fifo_full;
        seq_byte[ST_EMPTY] = fifo_empty;
        seq_byte[ST_OVF]   = ovf;
        seq_byte[ST_TOUT]  = tout;
      end
      TX_NAK:  seq_byte = NAK;
      default: seq_start = 1'b0;
    endcase
  end

  assign in_w        = (state == W_LEN) || (state == W_DATA);
  assign enter_fetch = seq_done && (((state == R_CNT) && (cnt != 8'd0)) ||
                                    ((state == R_SEND) && (cnt != 8'd1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fifo_wr  <= 1'b0;
      fifo_din <= 8'h00;
      fifo_rd  <= 1'b0;
      level    <= '0;
      ovf      <= 1'b0;
      tout     <= 1'b0;
      bcnt     <= 8'h00;
      cnt      <= 8'h00;
      rdata    <= 8'h00;
      tcnt     <= '0;
      zfill    <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      fifo_rd <= 1'b0;
      tcnt    <= (in_w && !rx_avail) ? tcnt + TW'(1) : '0;
      if (state == S_SEND && tx_wr) begin
        ovf  <= 1'b0;
        tout <= 1'b0;
      end
      case (state)
        IDLE: begin
          zfill <= 1'b0;
          if (rx_avail) begin
            case (rx_data)
              CMD_W:   state <= W_LEN;
              CMD_R:   state <= R_HDR;
              CMD_S:   state <= S_SEND;
              default: state <= TX_NAK;
            endcase
          end
        end
        W_LEN, W_DATA: begin
          if (rx_avail) begin
            if (state == W_LEN) begin
              bcnt  <= rx_data;
              state <= (rx_data == 8'd0) ? IDLE : W_DATA;
            end else begin
              bcnt <= bcnt - 8'd1;
              if (!fifo_full) begin
                fifo_wr  <= 1'b1;
                fifo_din <= rx_data;
                if (level != LVL_MAX) level <= level + LW'(1);
              end else begin
                ovf <= 1'b1;
              end
              if (bcnt == 8'd1) state <= IDLE;
            end
          end else if (tcnt == T_LAST) begin
            tout  <= 1'b1;
            state <= IDLE;
          end
        end
        R_HDR: if (seq_done) begin
          cnt   <= sat8(16'(level));
          state <= R_CNT;
        end
        R_CNT: if (seq_done) state <= (cnt == 8'd0) ? IDLE : R_FETCH;
        R_FETCH: state <= R_LAT;
        R_LAT: begin
          rdata <= zfill ? 8'h00 : fifo_dout;
          state <= R_SEND;
        end
        R_SEND: if (seq_done) begin
          cnt   <= cnt - 8'd1;
          state <= (cnt == 8'd1) ? IDLE : R_FETCH;
        end
        S_SEND, TX_NAK: if (seq_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      // fifo_rd is issued on entry so it is high during R_FETCH and data is
      // ready in R_LAT; an empty FIFO here means level and FIFO disagree.
      if (enter_fetch) begin
        if (fifo_empty || zfill) begin
          zfill <= 1'b1;
          ovf   <= 1'b1;
          level <= '0;
        end else begin
          fifo_rd <= 1'b1;
          if (level != '0) level <= level - LW'(1);
        end
      end
    end
  end

  uart_tx_seq u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .tx_byte (seq_byte),
    .tx_busy (tx_busy),
    .tx_wr   (tx_wr),
    .tx_data (tx_data),
    .done    (seq_done)
  );

endmodule

// File: doc/uart_fifo_ctrl.md
Name:
uart_fifo_ctrl

Overview:
- Single-clock command sequencer between the UART peripheral and the byte FIFO of the camera datapath.
- Decodes a byte protocol arriving on UART rx:
  - 'W' loads N bytes into the FIFO.
  - 'R' dumps the FIFO contents back over UART tx, framed.
  - 'S' returns a status byte.
- It is the sole writer and sole reader of the FIFO, and owns all tx_wr pulses.

Parameters:
- DEPTH, 16, FIFO depth in bytes; the occupancy counter is clog2(DEPTH)+1 bits wide.
- TIMEOUT, 100000, idle clk cycles allowed between rx bytes inside a 'W' transfer before it is aborted.
- HDR, 8'hA0, first byte of every 'R' response frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received UART byte; valid while rx_avail=1.
- rx_avail  in  1  one-cycle pulse per received byte.
- tx_data  out  8  byte to transmit; held stable from the tx_wr pulse until tx_busy falls.
- tx_wr  out  1  one-cycle transmit strobe.
- tx_busy  in  1  UART transmitter busy.
- fifo_wr  out  1  one-cycle FIFO write strobe.
- fifo_din  out  8  FIFO write data.
- fifo_rd  out  1  one-cycle FIFO read strobe.
- fifo_dout  in  8  FIFO read data; valid the cycle after fifo_rd.
- fifo_full  in  1  FIFO full.
- fifo_empty  in  1  FIFO empty.
- level  out  clog2(DEPTH)+1  occupancy counter.
- ovf  out  1  sticky overflow flag.
- tout  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync release)
  - tx_wr=0, tx_data=0, fifo_wr=0, fifo_din=0, fifo_rd=0, level=0, ovf=0, tout=0.
  - State goes to IDLE. The timeout counter and byte counter clear.
- IDLE
  - rx_avail with 0x57 ('W') -> W_LEN.
  - rx_avail with 0x52 ('R') -> R_HDR.
  - rx_avail with 0x53 ('S') -> S_SEND.
  - rx_avail with any other byte -> TX_NAK (sends 0xEE).
- W_LEN
  - The next rx byte is N. N=0 -> IDLE with no writes. Otherwise load the byte counter with N and go to W_DATA.
- W_DATA
  - Each rx_avail decrements the byte counter.
  - If fifo_full=0 on that cycle: fifo_wr=1 for one cycle, fifo_din=rx_data, level+1.
  - If fifo_full=1: the byte is dropped, ovf is set, level is unchanged.
  - When the counter reaches 0 -> IDLE.
- Timeout (W_LEN, W_DATA)
  - A cycle counter clears on every rx_avail.
  - Reaching TIMEOUT sets tout and returns to IDLE. Bytes already written stay in the FIFO.
- R_HDR
  - Send HDR, then R_CNT.
- R_CNT
  - Latch C = min(level, 255), send C, then R_FETCH.
  - C=0: after the count byte is sent, go to IDLE.
- R_FETCH
  - Assert fifo_rd for one cycle and decrement level. Next is R_LAT.
- R_LAT
  - One cycle. Capture fifo_dout into tx_data, then R_SEND.
- R_SEND
  - Transmit the captured byte and decrement C.
  - C=0 -> IDLE, otherwise -> R_FETCH.
  - If fifo_empty=1 when R_FETCH is entered (inconsistency), skip the read, send 0x00 for the remaining bytes, set ovf, and clear level.
- S_SEND
  - Send {fifo_full, fifo_empty, ovf, tout, 4'b0000}, then clear ovf and tout on the tx_wr cycle.
  - If an overflow occurs on that same cycle, set wins.
- Transmit sub-sequence (shared by all send states)
  - Wait until tx_busy=0, then pulse tx_wr for one cycle with tx_data stable.
  - Ignore tx_busy for one guard cycle, then wait for tx_busy=0 before advancing.
- rx_avail in any R_*, S_SEND or TX_NAK state is ignored; no queueing.
- level saturates at DEPTH and never underflows.
- A simultaneous write and read cannot occur, because the states are exclusive.

Decomposition:
- Package uart_fifo_pkg holds:
  - Command constants CMD_W=8'h57, CMD_R=8'h52, CMD_S=8'h53, NAK=8'hEE.
  - The state enum.
  - The status bit positions.
- One sub-module, uart_tx_seq: the tx_wr/guard/busy handshake. Inputs are start and byte; output is done.

Test Plan:
- Reset, then rx 'W',3,0x11,0x22,0x33 -> three fifo_wr pulses with din 11,22,33; level=3; state IDLE.
- Then rx 'R' -> tx bytes A0,03,11,22,33 in order; exactly 3 fifo_rd pulses; level=0. tx_wr never fires while tx_busy=1.
- DEPTH=16: rx 'W',18 followed by 18 bytes, with fifo_full held at 1 from the 17th byte -> 16 writes, ovf=1. Then 'S' -> tx 0xA0|... status byte = 8'b1010_0000 (full, ovf). ovf reads 0 afterwards.
- rx 'W',5,0x01, then silence for TIMEOUT+1 cycles -> tout=1, IDLE, level=1. Next 'W',1,0x02 is accepted normally.
- rx 0x7F -> tx 0xEE. rx 'R' with level=0 -> tx A0,00 and no fifo_rd.
- Assert reset mid-dump (during R_SEND) -> all outputs are 0 immediately and asynchronously. After release, IDLE; a following 'S' reports empty per fifo_empty.
